ta_feedback_bank: RTL
=====================

Name: ta_feedback_bank

Overview:
Trains one clause by holding and updating its Tsetlin Automata (TA), one TA per literal. It produces the exclude_state vector that the clause evaluator consumes, so it is the write side of that interface. It sits between the training controller, which supplies the feedback type, the sampled features, the clause output and random bits, and the clause evaluator. TAs are updated serially, one literal per cycle. exclude_state is refreshed atomically at the end of each pass.

Parameters:
NUM_FEATURES, 9, number of Boolean input features
NUM_LITERALS, 18, always 2*NUM_FEATURES; literal vector is {features, ~features}
STATE_BITS, 8, TA counter width; TA includes its literal iff state >= 2**(STATE_BITS-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
fb_valid  in  1  feedback request valid
fb_ready  out  1  block can accept a request; high only in IDLE
fb_type  in  2  2'b00 none, 2'b01 Type I, 2'b10 Type II, 2'b11 treated as none
features  in  NUM_FEATURES  feature sample the clause was evaluated on
clause_in  in  1  clause output for that sample
rand_bits  in  NUM_LITERALS  per-literal random bit, asserted with probability 1/s (LFSR external)
exclude_state  out  NUM_LITERALS  1 = literal excluded; registered
busy  out  1  high in UPDATE and DONE
update_done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - all TA states = 2**(STATE_BITS-1)-1 (127 at default).
  - exclude_state = all ones.
  - FSM goes to IDLE; fb_ready=1, busy=0, update_done=0.
  - Reset overrides any in-progress pass. No done pulse is issued for an aborted pass.
- FSM states: IDLE, UPDATE, DONE.
- IDLE:
  - fb_ready=1.
  - On fb_valid&&fb_ready, capture fb_type, literals={features,~features}, clause_in and rand_bits.
  - Type I or Type II: go to UPDATE with idx=0.
  - None or 2'b11: go directly to DONE; no state changes.
- UPDATE:
  - One TA per cycle, idx counts 0..NUM_LITERALS-1.
  - After idx=NUM_LITERALS-1, go to DONE.
  - fb_valid is ignored (not accepted) while fb_ready=0.
- DONE:
  - exclude_state[i] <= ~state[i][STATE_BITS-1] for all i, in a single cycle.
  - update_done=1 for one cycle; next state is IDLE.
- Latency: for Type I/II, accept at edge N, update_done high in cycle N+NUM_LITERALS+1 (N+19 at default), fb_ready back high in cycle N+20. For a no-op request, update_done is high in cycle N+1.
- exclude_state never changes outside the DONE cycle or reset. This keeps it consistent for the evaluator during a pass.
- Per-TA update for literal l, clause c, random bit r, include flag inc:
  - Type I, c=1, l=1: increment (unconditional, boosted true positive).
  - Type I, c=1, l=0: decrement if r.
  - Type I, c=0: decrement if r.
  - Type II, c=1, l=0, inc=0: increment.
  - Type II, all other cases: hold.
- Arithmetic saturates: increment at 2**STATE_BITS-1 holds; decrement at 0 holds. There is no wrap.
- Literal index mapping: bits [NUM_LITERALS-1:NUM_FEATURES] are features; bits [NUM_FEATURES-1:0] are ~features.

Decomposition:
- Shared header tm_defs.vh holds:
  - NUM_FEATURES, NUM_LITERALS, STATE_BITS defaults.
  - fb_type encodings FB_NONE/FB_TYPE1/FB_TYPE2.
  - FSM state encodings.
- One natural sub-module: ta_state_next. It is combinational and takes state, l, c, r, fb_type to produce next state, with saturation. It is instanced once and muxed by idx.

Test Plan:
1. Reset, then idle 5 cycles -> exclude_state=18'h3FFFF, fb_ready=1, busy=0, update_done never high.
2. From reset: Type I, clause_in=1, features=9'h1FF, rand_bits=0 -> update_done exactly 19 cycles after accept; exclude_state=18'h001FF; fb_ready high the next cycle.
3. From the state after test 2: Type I, clause_in=0, rand_bits=18'h3FFFF -> all states decrement (128->127, 127->126); exclude_state=18'h3FFFF.
4. From reset: Type II, clause_in=1, features=9'h1F0 -> zero-literal TAs increment 127->128; exclude_state=18'h3E00F.
5. Saturation: 130 Type I passes with clause_in=1, features=9'h1FF -> TA[17] counter stays at 255 (probed), no wrap; exclude_state[17]=0 throughout.
6. Boundary cases:
   - fb_valid held high during UPDATE -> no extra accept.
   - fb_type=2'b11 -> update_done one cycle after accept, exclude_state unchanged.
   - rst_n=0 at idx=7 -> next cycle exclude_state=18'h3FFFF, no update_done pulse.

Source files
------------

// File: rtl/ta_feedback_bank_pkg.sv
// ta_feedback_bank_pkg: shared defaults, feedback encodings and FSM states for clause training
package ta_feedback_bank_pkg;
  localparam int DEF_NUM_FEATURES = 9;
  localparam int DEF_STATE_BITS = 8;
  localparam logic [1:0] FB_NONE = 2'b00;
  localparam logic [1:0] FB_TYPE1 = 2'b01;
  localparam logic [1:0] FB_TYPE2 = 2'b10;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
endpackage

// File: rtl/ta_state_next.sv
// ta_state_next: saturating next-state of one Tsetlin Automaton under Type I/II feedback
module ta_state_next import ta_feedback_bank_pkg::*; #(
  parameter int STATE_BITS = DEF_STATE_BITS
) (
  input  logic [STATE_BITS-1:0] state,
  input  logic                  l,
  input  logic                  c,
  input  logic                  r,
  input  logic [1:0]            fb_type,
  output logic [STATE_BITS-1:0] nxt
);
  logic up, dn;
  assign up = (fb_type == FB_TYPE1 && c && l) || (fb_type == FB_TYPE2 && c && !l && !state[STATE_BITS-1]);
  assign dn = fb_type == FB_TYPE1 && r && !(c && l);
  assign nxt = (up && state != '1) ? state + 1'b1 : (dn && state != '0) ? state - 1'b1 : state;
endmodule

// File: rtl/ta_feedback_bank.sv
// ta_feedback_bank: serially trains one clause's TAs and publishes exclude_state once per pass
module ta_feedback_bank import ta_feedback_bank_pkg::*; #(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int NUM_LITERALS = 2 * NUM_FEATURES,
  parameter int STATE_BITS = DEF_STATE_BITS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fb_valid,
  output logic                    fb_ready,
  input  logic [1:0]              fb_type,
  input  logic [NUM_FEATURES-1:0] features,
  input  logic                    clause_in,
  input  logic [NUM_LITERALS-1:0] rand_bits,
  output logic [NUM_LITERALS-1:0] exclude_state,
  output logic                    busy,
  output logic                    update_done
);
  localparam int IW = $clog2(NUM_LITERALS);
  localparam logic [IW-1:0] LAST = IW'(NUM_LITERALS - 1);
  localparam logic [STATE_BITS-1:0] TA_RST = {1'b0, {(STATE_BITS-1){1'b1}}};
  state_t st;
  logic [IW-1:0] idx;
  logic [1:0] type_q;
  logic [NUM_LITERALS-1:0] lit_q, rnd_q;
  logic clause_q;
  logic [STATE_BITS-1:0] ta [NUM_LITERALS];
  logic [STATE_BITS-1:0] ta_nxt;
  ta_state_next #(.STATE_BITS(STATE_BITS)) u_next (
    .state(ta[idx]),
    .l(lit_q[idx]),
    .c(clause_q),
    .r(rnd_q[idx]),
    .fb_type(type_q),
    .nxt(ta_nxt)
  );
  // exclude_state only moves in DONE so the evaluator never sees a half-updated pass
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      idx <= '0;
      fb_ready <= 1'b1;
      busy <= 1'b0;
      update_done <= 1'b0;
      exclude_state <= '1;
      for (int i = 0; i < NUM_LITERALS; i++) ta[i] <= TA_RST;
    end else begin
      case (st)
        IDLE: if (fb_valid) begin
          type_q <= fb_type;
          lit_q <= {features, ~features};
          clause_q <= clause_in;
          rnd_q <= rand_bits;
          idx <= '0;
          fb_ready <= 1'b0;
          busy <= 1'b1;
          if (fb_type == FB_TYPE1 || fb_type == FB_TYPE2) st <= UPDATE;
          else begin
            st <= DONE;
            update_done <= 1'b1;
          end
        end
        UPDATE: begin
          ta[idx] <= ta_nxt;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            st <= DONE;
            update_done <= 1'b1;
          end
        end
        DONE: begin
          for (int i = 0; i < NUM_LITERALS; i++) exclude_state[i] <= ~ta[i][STATE_BITS-1];
          update_done <= 1'b0;
          busy <= 1'b0;
          fb_ready <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
